// File: rtl/voice_rom_scheduler.sv
// Three-voice sample fetcher: on each start tick, reads one sample per enabled
// voice from a shared synchronous ROM and publishes them together as one frame.
module voice_rom_scheduler #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            enables,
  input  logic [3*ADDR_W-1:0]   note_addrs,
  output logic                  rom_en,
  output logic [ADDR_W-1:0]     rom_addr,
  input  logic [DATA_W-1:0]     rom_data,
  output logic [3*DATA_W-1:0]   samples,
  output logic                  sample_valid,
  output logic                  busy,
  output logic                  overrun
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                state_q, state_d;
  logic [2:0]            en_q;
  logic [2:0]            remain_q, remain_d;
  logic [3*ADDR_W-1:0]   addr_q;
  logic                  pend_vld_q;
  logic [1:0]            pend_idx_q;
  logic [1:0]            cur_idx;
  logic [DATA_W-1:0]     work_q [3];
  logic [3*DATA_W-1:0]   samples_q, merged;
  logic                  overrun_q;
  logic                  accept;

  // Voice to issue this cycle: lowest index still outstanding.
  always_comb begin
    cur_idx = 2'd2;
    if (remain_q[0])      cur_idx = 2'd0;
    else if (remain_q[1]) cur_idx = 2'd1;
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    remain_d     = remain_q;
    rom_en       = 1'b0;
    rom_addr     = '0;
    busy         = 1'b0;
    sample_valid = 1'b0;
    accept       = 1'b0;
    case (state_q)
      IDLE:  accept = start;
      ISSUE: begin
        busy              = 1'b1;
        rom_en            = 1'b1;
        rom_addr          = addr_q[cur_idx*ADDR_W +: ADDR_W];
        remain_d[cur_idx] = 1'b0;
        if ((remain_q & ~(3'b001 << cur_idx)) == 3'b000) state_d = DRAIN;
      end
      DRAIN: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        sample_valid = 1'b1;
        state_d      = IDLE;
        accept       = start;
      end
      default: state_d = IDLE;
    endcase
    if (accept) begin
      remain_d = enables;
      state_d  = (enables != 3'b000) ? ISSUE : DRAIN;
    end
    // Reset dominates: outputs go quiet in the very cycle rst is seen.
    if (rst) begin
      rom_en       = 1'b0;
      rom_addr     = '0;
      busy         = 1'b0;
      sample_valid = 1'b0;
      accept       = 1'b0;
    end
  end

  // The last datum arrives during DRAIN, so fold it in directly from rom_data.
  always_comb begin
    merged = '0;
    for (int i = 0; i < 3; i++) begin
      if (en_q[i])
        merged[i*DATA_W +: DATA_W] = (pend_vld_q && pend_idx_q == 2'(i)) ? rom_data : work_q[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      remain_q   <= '0;
      pend_vld_q <= 1'b0;
      pend_idx_q <= '0;
      samples_q  <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      remain_q   <= remain_d;
      pend_vld_q <= rom_en;
      pend_idx_q <= cur_idx;
      if (start && busy)     overrun_q <= 1'b1;
      if (state_q == DRAIN)  samples_q <= merged;
    end
  end

  // NOTE: snapshot and working registers carry no reset; they are always written before being read.
  always_ff @(posedge clk) begin
    if (accept) begin
      en_q   <= enables;
      addr_q <= note_addrs;
    end
    if (pend_vld_q) work_q[pend_idx_q] <= rom_data;
  end

  assign samples = samples_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_voice_rom_scheduler.sv
// Self-checking bench for voice_rom_scheduler with a behavioural synchronous ROM
// and a scoreboard of expected ROM addresses and sample frames.
module tb_voice_rom_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  enables = '0;
  logic [35:0] note_addrs = '0;
  logic        rom_en;
  logic [11:0] rom_addr;
  logic [7:0]  rom_data = '0;
  logic [23:0] samples;
  logic        sample_valid, busy, overrun;

  int n_checks = 0;
  int n_errors = 0;
  logic        exp_ovr = 1'b0;
  logic [23:0] exp_samp_cur = '0;
  logic [11:0] addr_sb [$];
  logic [23:0] samp_sb [$];

  voice_rom_scheduler #(.ADDR_W(12), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .enables(enables), .note_addrs(note_addrs),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_data(rom_data), .samples(samples),
    .sample_valid(sample_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_f(input logic [11:0] a);
    return a[7:0] + 8'd1;
  endfunction

  // Synchronous ROM; garbage on idle cycles so stray captures show up.
  always @(posedge clk) rom_data <= rom_en ? rom_f(rom_addr) : 8'($urandom);

  // Starts a sweep in the current cycle N and checks cycles N+1..N+k+2.
  // ovr_at: cycle offset at which a second (illegal) start is pulsed; chg_at: offset at which inputs are scrambled.
  task automatic do_sweep(input logic [2:0] en, input logic [35:0] addrs, input int ovr_at, input int chg_at);
    int k;
    logic [11:0] a, exp_addr;
    logic [23:0] fin, exp_s;
    logic exp_en;
    k = 0; fin = '0;
    for (int i = 0; i < 3; i++) begin
      if (en[i]) begin
        a = addrs[i*12 +: 12];
        addr_sb.push_back(a);
        fin[i*8 +: 8] = rom_f(a);
        k++;
      end
    end
    samp_sb.push_back(fin);
    start = 1'b1; enables = en; note_addrs = addrs;
    for (int c = 1; c <= k + 2; c++) begin
      @(negedge clk);
      start = 1'b0;
      exp_en   = (c <= k);
      exp_addr = exp_en ? addr_sb.pop_front() : 12'h000;
      exp_s    = (c == k + 2) ? samp_sb.pop_front() : exp_samp_cur;
      n_checks += 6;
      if (rom_en !== exp_en) begin n_errors++; $display("FAIL sweep c%0d rom_en: got %b want %b", c, rom_en, exp_en); end
      if (rom_addr !== exp_addr) begin n_errors++; $display("FAIL sweep c%0d rom_addr: got %h want %h", c, rom_addr, exp_addr); end
      if (busy !== (c <= k + 1)) begin n_errors++; $display("FAIL sweep c%0d busy: got %b want %b", c, busy, c <= k + 1); end
      if (sample_valid !== (c == k + 2)) begin n_errors++; $display("FAIL sweep c%0d sample_valid: got %b want %b", c, sample_valid, c == k + 2); end
      if (overrun !== exp_ovr) begin n_errors++; $display("FAIL sweep c%0d overrun: got %b want %b", c, overrun, exp_ovr); end
      if (samples !== exp_s) begin n_errors++; $display("FAIL sweep c%0d samples: got %h want %h", c, samples, exp_s); end
      if (c == k + 2) exp_samp_cur = exp_s;
      if (c == chg_at) begin
        enables = ~en;
        note_addrs = 36'({$urandom(), $urandom()});
      end
      if (c == ovr_at) begin
        start = 1'b1;
        exp_ovr = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; enables = 3'b111; note_addrs = {12'h300, 12'h200, 12'h100};
    repeat (3) @(negedge clk);
    n_checks += 6;
    if (rom_en !== 1'b0) begin n_errors++; $display("FAIL reset rom_en: got %b want 0", rom_en); end
    if (rom_addr !== 12'h000) begin n_errors++; $display("FAIL reset rom_addr: got %h want 000", rom_addr); end
    if (samples !== 24'h0) begin n_errors++; $display("FAIL reset samples: got %h want 0", samples); end
    if (sample_valid !== 1'b0) begin n_errors++; $display("FAIL reset sample_valid: got %b want 0", sample_valid); end
    if (busy !== 1'b0) begin n_errors++; $display("FAIL reset busy: got %b want 0", busy); end
    if (overrun !== 1'b0) begin n_errors++; $display("FAIL reset overrun: got %b want 0", overrun); end
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    n_checks += 2;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_prio busy: got %b want 0", busy); end
    if (rom_en !== 1'b0) begin n_errors++; $display("FAIL reset_prio rom_en: got %b want 0", rom_en); end
  endtask

  task automatic test_all_voices();
    do_sweep(3'b111, {12'h300, 12'h200, 12'h100}, 0, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_sparse();
    do_sweep(3'b101, {12'h020, 12'h0ab, 12'h010}, 0, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_no_voices();
    do_sweep(3'b000, {12'h123, 12'h456, 12'h789}, 0, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_snapshot();
    do_sweep(3'b011, {12'h5c3, 12'h4a7, 12'h3fe}, 0, 1);
    repeat (2) @(negedge clk);
  endtask

  // Second start lands in the DONE cycle, so the two sweeps run back to back.
  task automatic test_overrun_back_to_back();
    do_sweep(3'b111, {12'h333, 12'h222, 12'h111}, 2, 0);
    do_sweep(3'b110, {12'h0f0, 12'h07e, 12'h999}, 0, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    start = 1'b1; enables = 3'b111; note_addrs = {12'h3aa, 12'h2bb, 12'h1cc};
    @(negedge clk);
    start = 1'b0;
    n_checks += 2;
    if (rom_en !== 1'b1 || rom_addr !== 12'h1cc) begin n_errors++; $display("FAIL rst_mid c1 rom: got %b/%h want 1/1cc", rom_en, rom_addr); end
    if (busy !== 1'b1) begin n_errors++; $display("FAIL rst_mid c1 busy: got %b want 1", busy); end
    @(negedge clk);
    n_checks++;
    if (rom_en !== 1'b1 || rom_addr !== 12'h2bb) begin n_errors++; $display("FAIL rst_mid c2 rom: got %b/%h want 1/2bb", rom_en, rom_addr); end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({rom_en, rom_addr, samples, sample_valid, busy, overrun} !== '0)
      begin n_errors++; $display("FAIL rst_mid c3 outputs: got en=%b a=%h s=%h v=%b b=%b o=%b want all 0", rom_en, rom_addr, samples, sample_valid, busy, overrun); end
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_checks++;
      if (sample_valid !== 1'b0 || rom_en !== 1'b0 || busy !== 1'b0 || samples !== 24'h0)
        begin n_errors++; $display("FAIL rst_mid quiet%0d: got v=%b en=%b b=%b s=%h want 0", c, sample_valid, rom_en, busy, samples); end
    end
    exp_ovr = 1'b0;
    exp_samp_cur = '0;
    do_sweep(3'b111, {12'h300, 12'h200, 12'h100}, 0, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      do_sweep(3'($urandom), 36'({$urandom(), $urandom()}), 0, 0);
      if ($urandom_range(1, 0) == 1) repeat ($urandom_range(3, 1)) @(negedge clk);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_all_voices();
    test_sparse();
    test_no_voices();
    test_snapshot();
    test_overrun_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
